// File: rtl/br_fifo_shared_pstatic_ptr_ctrl.sv
// rtl/br_fifo_shared_pstatic_ptr_ctrl.sv - pointer/occupancy controller for a shared pseudo-static multi-FIFO
// One push and one pop per cycle, each tagged with a FIFO id; regions wrap at their inclusive bound.
module br_fifo_shared_pstatic_ptr_ctrl #(
  parameter int NumFifos = 2,
  parameter int Depth = 8,
  localparam int AddrWidth = (Depth <= 1) ? 1 : $clog2(Depth),
  localparam int CountWidth = $clog2(Depth + 1),
  localparam int IdWidth = (NumFifos <= 1) ? 1 : $clog2(NumFifos)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NumFifos*AddrWidth-1:0]  config_base,
  input  logic [NumFifos*AddrWidth-1:0]  config_bound,
  input  logic                           config_error,
  input  logic                           push_valid,
  input  logic [IdWidth-1:0]             push_fifo_id,
  output logic                           push_ready,
  output logic [AddrWidth-1:0]           push_addr,
  input  logic                           pop_valid,
  input  logic [IdWidth-1:0]             pop_fifo_id,
  output logic                           pop_ready,
  output logic [AddrWidth-1:0]           pop_addr,
  output logic [NumFifos-1:0]            fifo_empty,
  output logic [NumFifos-1:0]            fifo_full,
  output logic [NumFifos*CountWidth-1:0] fifo_count,
  output logic                           ctrl_error
);

  typedef enum logic [1:0] {
    StInit   = 2'd0,
    StActive = 2'd1,
    StError  = 2'd2
  } state_e;

  state_e state_q;
  logic   ctrl_error_q;

  logic [AddrWidth-1:0]  base       [NumFifos];
  logic [AddrWidth-1:0]  bound      [NumFifos];
  logic [CountWidth-1:0] size       [NumFifos];

  logic [AddrWidth-1:0]  wr_ptr_q   [NumFifos];
  logic [AddrWidth-1:0]  wr_ptr_d   [NumFifos];
  logic [AddrWidth-1:0]  rd_ptr_q   [NumFifos];
  logic [AddrWidth-1:0]  rd_ptr_d   [NumFifos];
  logic [CountWidth-1:0] count_q    [NumFifos];
  logic [CountWidth-1:0] count_d    [NumFifos];
  logic [NumFifos-1:0]   empty_q;
  logic [NumFifos-1:0]   full_q;
  logic [NumFifos-1:0]   push_fire;
  logic [NumFifos-1:0]   pop_fire;

  logic push_id_ok;
  logic pop_id_ok;
  logic active;

  function automatic logic [AddrWidth-1:0] next_ptr(input logic [AddrWidth-1:0] ptr,
                                                    input logic [AddrWidth-1:0] lo,
                                                    input logic [AddrWidth-1:0] hi);
    return (ptr == hi) ? lo : ptr + AddrWidth'(1);
  endfunction

  always_comb begin
    for (int i = 0; i < NumFifos; i++) begin
      base[i]  = config_base[i*AddrWidth +: AddrWidth];
      bound[i] = config_bound[i*AddrWidth +: AddrWidth];
      size[i]  = CountWidth'(bound[i]) - CountWidth'(base[i]) + CountWidth'(1);
    end
  end

  assign active     = (state_q == StActive);
  assign push_id_ok = (int'(push_fifo_id) < NumFifos);
  assign pop_id_ok  = (int'(pop_fifo_id) < NumFifos);

  // Ready looks only at registered counts: no push->pop or pop->push bypass.
  always_comb begin
    push_ready = 1'b0;
    pop_ready  = 1'b0;
    push_addr  = '0;
    pop_addr   = '0;
    if (push_id_ok) begin
      push_ready = active && (count_q[push_fifo_id] != size[push_fifo_id]);
      push_addr  = wr_ptr_q[push_fifo_id];
    end
    if (pop_id_ok) begin
      pop_ready = active && (count_q[pop_fifo_id] != '0);
      pop_addr  = rd_ptr_q[pop_fifo_id];
    end
  end

  always_comb begin
    for (int i = 0; i < NumFifos; i++) begin
      push_fire[i] = push_valid && push_ready && (push_fifo_id == IdWidth'(i));
      pop_fire[i]  = pop_valid && pop_ready && (pop_fifo_id == IdWidth'(i));
      wr_ptr_d[i]  = push_fire[i] ? next_ptr(wr_ptr_q[i], base[i], bound[i]) : wr_ptr_q[i];
      rd_ptr_d[i]  = pop_fire[i] ? next_ptr(rd_ptr_q[i], base[i], bound[i]) : rd_ptr_q[i];
      case ({push_fire[i], pop_fire[i]})
        2'b10:   count_d[i] = count_q[i] + CountWidth'(1);
        2'b01:   count_d[i] = count_q[i] - CountWidth'(1);
        default: count_d[i] = count_q[i];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StInit;
      ctrl_error_q <= 1'b0;
    end else begin
      case (state_q)
        StInit: begin
          if (config_error) begin
            state_q      <= StError;
            ctrl_error_q <= 1'b1;
          end else begin
            state_q <= StActive;
          end
        end
        StActive: state_q <= StActive;
        StError:  ctrl_error_q <= 1'b1;
        default: begin
          state_q      <= StError;
          ctrl_error_q <= 1'b1;
        end
      endcase
    end
  end

  // Pointers load from config in INIT; in ERROR everything stays frozen.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NumFifos; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      empty_q <= '1;
      full_q  <= '0;
    end else if (state_q == StInit) begin
      if (!config_error) begin
        for (int i = 0; i < NumFifos; i++) begin
          wr_ptr_q[i] <= base[i];
          rd_ptr_q[i] <= base[i];
        end
      end
    end else if (state_q == StActive) begin
      for (int i = 0; i < NumFifos; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        count_q[i]  <= count_d[i];
        empty_q[i]  <= (count_d[i] == '0);
        full_q[i]   <= (count_d[i] == size[i]);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NumFifos; i++) begin
      fifo_count[i*CountWidth +: CountWidth] = count_q[i];
    end
  end

  assign fifo_empty = empty_q;
  assign fifo_full  = full_q;
  assign ctrl_error = ctrl_error_q;

  a_push_id_range: assert property (@(posedge clk) disable iff (!rst)
    (active && push_valid) |-> push_id_ok);
  a_pop_id_range: assert property (@(posedge clk) disable iff (!rst)
    (active && pop_valid) |-> pop_id_ok);

endmodule

// File: doc/br_fifo_shared_pstatic_ptr_ctrl.md
Name: br_fifo_shared_pstatic_ptr_ctrl

Overview:
- Pointer and occupancy controller for a shared pseudo-static multi-FIFO.
- A single RAM of Depth entries is partitioned into NumFifos contiguous regions, each described by a [base, bound] pair.
- The block arbitrates nothing. It sequences one push and one pop per cycle, each tagged with a FIFO id, and produces the RAM write/read addresses.
- It tracks a per-FIFO write pointer, read pointer and count, with wrap-around at each region's bound.
- It sits between the push/pop interfaces and the shared RAM, alongside the config size/error checker.

Parameters:
- NumFifos, 2, number of logical FIFOs (>=1).
- Depth, 8, total shared RAM entries (>=NumFifos).
- AddrWidth, br_math::clamped_clog2(Depth), localparam, RAM address width.
- CountWidth, $clog2(Depth+1), localparam, per-FIFO count width.
- IdWidth, br_math::clamped_clog2(NumFifos), localparam, FIFO id width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-low reset (0 = reset asserted).
- config_base  input  NumFifos*AddrWidth  per-FIFO region base; stable while rst=1.
- config_bound  input  NumFifos*AddrWidth  per-FIFO region bound, inclusive; stable while rst=1.
- config_error  input  1  misconfiguration flag from the size checker.
- push_valid  input  1  push request.
- push_fifo_id  input  IdWidth  target FIFO of the push.
- push_ready  output  1  push may be accepted this cycle.
- push_addr  output  AddrWidth  RAM write address; valid when push_valid & push_ready.
- pop_valid  input  1  pop request.
- pop_fifo_id  input  IdWidth  source FIFO of the pop.
- pop_ready  output  1  pop may be accepted this cycle.
- pop_addr  output  AddrWidth  RAM read address; valid when pop_valid & pop_ready.
- fifo_empty  output  NumFifos  per-FIFO empty, registered.
- fifo_full  output  NumFifos  per-FIFO full, registered.
- fifo_count  output  NumFifos*CountWidth  per-FIFO occupancy, registered.
- ctrl_error  output  1  sticky configuration-error state.

Behaviour:
- FSM states: INIT, ACTIVE, ERROR.
- Reset (rst=0) forces:
  - state=INIT; all wr_ptr/rd_ptr=0; all counts=0.
  - fifo_empty=all-ones, fifo_full=0, ctrl_error=0.
- INIT, lasting exactly one cycle after rst deasserts:
  - If config_error=1: go to ERROR.
  - Otherwise: wr_ptr[i]=rd_ptr[i]=config_base[i], then go to ACTIVE.
  - push_ready=pop_ready=0 while in INIT.
- ERROR: terminal until reset. ctrl_error=1, push_ready=pop_ready=0, pointers and counts frozen.
- ACTIVE:
  - config_error is ignored; config is static after init.
  - size[i]=bound[i]-base[i]+1, computed in CountWidth.
  - push_ready = (fifo_count[push_fifo_id] != size[push_fifo_id]). Combinational on registered count; no same-cycle pop bypass.
  - pop_ready = (fifo_count[pop_fifo_id] != 0). No same-cycle push bypass; a pushed entry is poppable the next cycle.
  - push_addr = wr_ptr[push_fifo_id]; pop_addr = rd_ptr[pop_fifo_id]. Combinational, zero latency.
  - On an accepted push: wr_ptr[id] = (wr_ptr==bound[id]) ? base[id] : wr_ptr+1.
  - On an accepted pop: rd_ptr advances by the same rule.
- Count update per FIFO, registered next cycle:
  - +1 if pushed only; -1 if popped only.
  - Unchanged if pushed and popped in the same cycle, which is allowed for the same id when 0<count<size.
- fifo_empty[i]=(count==0) and fifo_full[i]=(count==size[i]), both registered. They update one cycle after the accepting edge, together with count.
- Pushes and pops on different ids are fully independent in the same cycle.
- Valid/ready rules:
  - push_ready and pop_ready may depend on push_valid/pop_valid and the ids.
  - Once valid is asserted, the requester holds valid and id stable until accepted (integration assertion).
  - An out-of-range id (>=NumFifos) is an integration assertion failure.
- Single-entry FIFO (base==bound): pointers never move off base; count toggles between 0 and 1.
- Reset mid-operation discards all contents and returns to INIT; contents are not preserved.

Test Plan (NumFifos=2, Depth=8, FIFO0=[0,3], FIFO1=[4,7] unless stated):
- Reset release with config_error=0 -> one INIT cycle with ready=0, then ACTIVE; push_addr for id1 = 4, fifo_empty=2'b11.
- Push 4 to id0 -> push_addr 0,1,2,3; fifo_full[0]=1 and count0=4 the cycle after the 4th push; a 5th push sees push_ready=0.
- Fill id0, pop 2 (pop_addr 0,1), push 2 -> push_addr 0,1 (wrap at bound 3); count0=4.
- id1 at count 2: simultaneous push and pop on id1 -> count1 stays 2; push_addr and pop_addr each advance by 1.
- config_error=1 during INIT -> ERROR, ctrl_error=1, push_ready=pop_ready=0 indefinitely; rst=0 then clears to INIT.
- base=bound=5 for FIFO1 -> push at addr 5, count1=1 and full; pop at addr 5, empty; repeat 3 times, address stays 5.
